sram_pingpong_ctrl: RTL and testbench
=====================================

# sram_pingpong_ctrl

Double-buffer (ping-pong) controller for one `SRAM` instance holding two K/V tiles of `TILE_ROWS` rows each. A producer streams rows into one bank while the attention datapath streams rows out of the other. The consumer may replay a full tile any number of times before releasing it, matching FlashAttention's reuse of a K/V tile across Q rows. The block sits between the tile loader and the QK/PV compute units, and drives the SRAM's single write port and read port 0 (non-bypass).

## Interface
- `WIDTH`, 32, row width in bits.
- `TILE_ROWS`, 16, rows per tile; power of two, ≥2. SRAM depth is `2*TILE_ROWS`.
- `AW`, `$clog2(2*TILE_ROWS)`, derived SRAM address width; address = {bank, row}.

Ports:
- `clock`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  producer row valid.
- `wr_ready`  out  1  = !full[wr_bank].
- `wr_data`  in  WIDTH  producer row.
- `rd_valid`  out  1  registered output row valid.
- `rd_ready`  in  1  consumer accepts row.
- `rd_data`  out  WIDTH  registered row.
- `rd_last`  out  1  row is `TILE_ROWS-1` of the tile.
- `rd_release`  in  1  sampled only on a last-beat handshake; 1 frees the bank, 0 replays it.
- `sram_we`, `sram_waddr[AW]`, `sram_wdata[WIDTH]`  out  SRAM write port.
- `sram_re`, `sram_raddr[AW]`  out  SRAM read port 0.
- `sram_rdata`  in  WIDTH  combinational SRAM read data.

## Operation
- State: `wr_bank`, `wr_row`, `rd_bank`, `rd_row`, `full[1:0]`, and reader FSM `IDLE`/`STREAM`/`HOLD_LAST`.
- Write side: `sram_we = wr_valid & wr_ready`, `sram_waddr = {wr_bank, wr_row}`, `sram_wdata = wr_data`.
  - Each accepted row increments `wr_row`.
  - On row `TILE_ROWS-1`: set `full[wr_bank]`, toggle `wr_bank`, and set `wr_row` to 0.
- Reader FSM:
  - `IDLE`: go to `STREAM` when `full[rd_bank]`.
  - `STREAM`: issue a fetch when `!rd_valid | rd_ready`. A fetch is `sram_re=1`, `sram_raddr={rd_bank, rd_row}`, with `rd_data <= sram_rdata`, `rd_valid <= 1`, `rd_last <= (rd_row==TILE_ROWS-1)`.
    - Fetch of row `TILE_ROWS-1` → `HOLD_LAST`, `rd_row` ← 0. Otherwise `rd_row` increments.
  - `HOLD_LAST`: no fetch. On `rd_valid & rd_ready`:
    - `rd_release=1`: clear `full[rd_bank]`, toggle `rd_bank`, go to `IDLE`.
    - `rd_release=0`: go to `STREAM` on the same bank, i.e. replay.
  - On any cycle with `rd_ready & !fetch`: `rd_valid` ← 0.
- `sram_re=0` whenever no fetch is issued.
- The two banks are always disjoint during simultaneous read and write, so no bypass is needed.
- Producer and consumer on the same bank cannot conflict:
  - A write needs `!full`.
  - A read needs `full`.
  - A release and a write-stall on the same bank in the same cycle is legal. The write is accepted the following cycle.
- An async `reset` mid-tile discards all state; partially written tiles are lost.
- `rd_release` is ignored except on a last-beat handshake.

## Timing
- Reset values:
  - `wr_bank=rd_bank=0`, `wr_row=rd_row=0`, `full=2'b00`, FSM=`IDLE`.
  - `rd_valid=0`, `rd_last=0`, `rd_data=0`.
  - `wr_ready=1`, `sram_we=0`, `sram_re=0`.
- Write: 0-cycle acceptance; the row is in SRAM at the next edge.
- Fill-to-read latency:
  - The last write edge sets `full`.
  - `IDLE→STREAM` at the next edge.
  - The first fetch at the following edge makes `rd_valid=1`.
  - Total: `rd_valid` rises 3 edges after the last write edge.
- Streaming: 1 row/cycle with `rd_ready` held high.
- Per pass: 1 bubble cycle after the last beat (the `HOLD_LAST` handshake, then re-entry to `STREAM`).
- Freed bank: `wr_ready` rises the cycle after the release edge.

## Configuration
- `SRAM_PP_PERF_EN` defined adds two outputs. Both reset to 0 and saturate at all-ones.
  - `perf_wr_stall[31:0]`: counts cycles with `wr_valid & !wr_ready`.
  - `perf_rd_stall[31:0]`: counts cycles with `rd_valid & !rd_ready`.
- Undefined: these ports and counters do not exist, and functional behaviour is identical.

## Test plan
All scenarios use `WIDTH=32`, `TILE_ROWS=4`.
- Reset then write rows 0xA0..0xA3, `rd_ready=1`, `rd_release=1` on last → `rd_data` 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, `rd_last` only on 0xA3, `sram_raddr` 0..3.
- Write 8 rows 0xB0..0xB7 with the reader stalled → `wr_ready`=0 after 8 accepts; bank 1 holds 0xB4..0xB7 at SRAM addresses 4..7.
- Replay: `rd_release=0` on the first pass, 1 on the second → 0xA0..0xA3 streamed twice with one bubble between, then `full[0]` clears.
- `rd_ready` toggled 1,0,1,0 → each row held stable while `rd_valid & !rd_ready`; no row skipped or duplicated.
- Release of bank 0 in the same cycle a 9th write is stalled → the write is accepted the next cycle at address 0.
- Assert `reset` low mid-stream, then release → all outputs at reset values; the next tile writes to addresses 0..3.

Source files
------------

// File: rtl/sram_pingpong_ctrl.sv
// sram_pingpong_ctrl: two-bank ping-pong tile buffer controller over one SRAM, with tile replay.
// Optional macro SRAM_PP_PERF_EN adds saturating write/read stall counters.
module sram_pingpong_ctrl #(
    parameter int WIDTH     = 32,
    parameter int TILE_ROWS = 16,
    parameter int AW        = $clog2(2 * TILE_ROWS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_last,
    input  logic             rd_release,
    output logic             sram_we,
    output logic [AW-1:0]    sram_waddr,
    output logic [WIDTH-1:0] sram_wdata,
    output logic             sram_re,
    output logic [AW-1:0]    sram_raddr,
`ifdef SRAM_PP_PERF_EN
    output logic [31:0]      perf_wr_stall,
    output logic [31:0]      perf_rd_stall,
`endif
    input  logic [WIDTH-1:0] sram_rdata
);
    localparam int RW = AW - 1;
    localparam logic [RW-1:0] ROW_MAX = RW'(TILE_ROWS - 1);

    typedef enum logic [1:0] {IDLE, STREAM, HOLD_LAST} state_t;

    state_t           state_q, state_d;
    logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [RW-1:0]    wr_row_q, wr_row_d, rd_row_q, rd_row_d;
    logic [1:0]       full_q, full_d;
    logic             rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             wr_fire, wr_tile_done, fetch, last_hs, release_bank;

    assign wr_ready     = !full_q[wr_bank_q];
    assign wr_fire      = wr_valid & wr_ready;
    assign wr_tile_done = wr_fire & (wr_row_q == ROW_MAX);
    assign fetch        = (state_q == STREAM) & (!rd_valid_q | rd_ready);
    assign last_hs      = (state_q == HOLD_LAST) & rd_valid_q & rd_ready;
    assign release_bank = last_hs & rd_release;

    assign sram_we    = wr_fire;
    assign sram_waddr = {wr_bank_q, wr_row_q};
    assign sram_wdata = wr_data;
    assign sram_re    = fetch;
    assign sram_raddr = {rd_bank_q, rd_row_q};
    assign rd_valid   = rd_valid_q;
    assign rd_last    = rd_last_q;
    assign rd_data    = rd_data_q;

    // Next state: row counters wrap naturally at the power-of-two tile size
    always_comb begin
        wr_row_d   = wr_fire ? wr_row_q + RW'(1) : wr_row_q;
        wr_bank_d  = wr_bank_q ^ wr_tile_done;
        rd_row_d   = fetch ? rd_row_q + RW'(1) : rd_row_q;
        rd_bank_d  = rd_bank_q ^ release_bank;
        full_d     = full_q;
        if (wr_tile_done) full_d[wr_bank_q] = 1'b1;
        if (release_bank) full_d[rd_bank_q] = 1'b0;
        rd_valid_d = fetch | (rd_valid_q & !rd_ready);
        rd_last_d  = fetch ? (rd_row_q == ROW_MAX) : rd_last_q;
        rd_data_d  = fetch ? sram_rdata : rd_data_q;
        state_d    = state_q;
        unique case (state_q)
            IDLE:      state_d = full_q[rd_bank_q] ? STREAM : IDLE;
            STREAM:    state_d = (fetch && rd_row_q == ROW_MAX) ? HOLD_LAST : STREAM;
            HOLD_LAST: state_d = last_hs ? (rd_release ? IDLE : STREAM) : HOLD_LAST;
            default:   state_d = IDLE;
        endcase
    end

    // State registers, all cleared by the asynchronous reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_row_q   <= '0;
            rd_row_q   <= '0;
            full_q     <= 2'b00;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_row_q   <= wr_row_d;
            rd_row_q   <= rd_row_d;
            full_q     <= full_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_data_q  <= rd_data_d;
        end
    end

`ifdef SRAM_PP_PERF_EN
    logic [31:0] perf_wr_q, perf_wr_d, perf_rd_q, perf_rd_d;

    assign perf_wr_stall = perf_wr_q;
    assign perf_rd_stall = perf_rd_q;

    // Saturating stall counters: hold at all-ones instead of wrapping
    always_comb begin
        perf_wr_d = perf_wr_q + {31'd0, wr_valid & !wr_ready & ~&perf_wr_q};
        perf_rd_d = perf_rd_q + {31'd0, rd_valid_q & !rd_ready & ~&perf_rd_q};
    end

    // Counter registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_wr_q <= '0;
            perf_rd_q <= '0;
        end else begin
            perf_wr_q <= perf_wr_d;
            perf_rd_q <= perf_rd_d;
        end
    end
`endif
endmodule

// File: tb/tb_sram_pingpong_ctrl.sv
// tb_sram_pingpong_ctrl: directed plus random check of sram_pingpong_ctrl against a tile-queue model.
module tb_sram_pingpong_ctrl;
    localparam int W  = 32;
    localparam int TR = 4;
    localparam int AW = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [W-1:0]  wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [W-1:0]  rd_data;
    logic          rd_last;
    logic          rd_release = 1'b0;
    logic          sram_we;
    logic [AW-1:0] sram_waddr;
    logic [W-1:0]  sram_wdata;
    logic          sram_re;
    logic [AW-1:0] sram_raddr;
    logic [W-1:0]  sram_rdata;
    logic [W-1:0]  mem [2*TR];

    always #5 clock = ~clock;

    always @(posedge clock) if (sram_we) mem[sram_waddr] <= sram_wdata;
    assign sram_rdata = mem[sram_raddr];

    sram_pingpong_ctrl #(.WIDTH(W), .TILE_ROWS(TR)) dut (
        .clock(clock), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_last(rd_last), .rd_release(rd_release),
        .sram_we(sram_we), .sram_waddr(sram_waddr), .sram_wdata(sram_wdata),
        .sram_re(sram_re), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Model: pending producer words, the tile being filled, and completed tiles in order
    logic [31:0] pq[$];
    logic [31:0] cur[$];
    logic [31:0] done_q[$];
    int hs_steps[$];
    int wrow, wtiles, rtiles, beat, fetch_cnt, pass_cnt, cyc;
    int tile_done_step, first_valid_step, rel_step, acc_step;
    bit prod_en;
    logic prev_v, prev_r;
    logic [31:0] prev_d;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_clear();
        pq.delete(); cur.delete(); done_q.delete(); hs_steps.delete();
        wrow = 0; wtiles = 0; rtiles = 0; beat = 0; fetch_cnt = 0; pass_cnt = 0; cyc = 0;
        tile_done_step = -1; first_valid_step = -1; rel_step = -1; acc_step = -1;
        prev_v = 1'b0; prev_r = 1'b0; prev_d = '0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        #2;
        reset = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; rd_release = 1'b0;
        #1;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_sram_we", sram_we, 0);
        chk("rst_sram_re", sram_re, 0);
        model_clear();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic step(input logic rr, input logic rel);
        int held;
        bit wacc;
        @(negedge clock);
        wr_valid = prod_en && pq.size() > 0;
        wr_data = (pq.size() > 0) ? pq[0] : '0;
        rd_ready = rr;
        rd_release = rel;
        #1;
        held = done_q.size() / TR;
        wacc = wr_valid && held < 2;
        chk("wr_ready", wr_ready, held < 2);
        chk("sram_we", sram_we, wacc);
        if (prev_v && !prev_r) begin
            chk("rd_valid_hold", rd_valid, 1);
            chk("rd_data_hold", rd_data, prev_d);
        end
        if (wacc) begin
            chk("sram_waddr", sram_waddr, (wtiles % 2) * TR + wrow);
            chk("sram_wdata", sram_wdata, wr_data);
        end
        if (sram_re) begin
            chk("sram_raddr", sram_raddr, (rtiles % 2) * TR + fetch_cnt % TR);
            fetch_cnt++;
        end
        if (rd_valid) begin
            if (first_valid_step < 0) first_valid_step = cyc;
            if (held == 0) chk("rd_valid_no_tile", rd_valid, 0);
            else begin
                chk("rd_data", rd_data, done_q[beat]);
                chk("rd_last", rd_last, beat == TR - 1);
            end
        end
        if (rd_valid && rr && held > 0) begin
            hs_steps.push_back(cyc);
            beat++;
            if (beat == TR) begin
                beat = 0;
                pass_cnt++;
                if (rel) begin
                    repeat (TR) void'(done_q.pop_front());
                    rtiles++;
                    rel_step = cyc;
                end
            end
        end
        if (wacc) begin
            cur.push_back(pq.pop_front());
            acc_step = cyc;
            wrow++;
            if (wrow == TR) begin
                foreach (cur[i]) done_q.push_back(cur[i]);
                cur.delete();
                wrow = 0;
                wtiles++;
                tile_done_step = cyc;
            end
        end
        prev_v = rd_valid; prev_r = rr; prev_d = rd_data;
        cyc++;
    endtask

    initial begin
        int k;
        model_clear();
        prod_en = 1'b1;

        apply_reset();
        for (int i = 0; i < 4; i++) pq.push_back(32'hA0 + i);
        k = 0;
        while (rtiles < 1 && k < 40) begin step(1, 1); k++; end
        chk("s1_released", rtiles, 1);
        chk("s1_fill_latency", first_valid_step - tile_done_step, 3);
        chk("s1_back_to_back", hs_steps.size() == 4 ? hs_steps[3] - hs_steps[0] : -1, 3);

        apply_reset();
        for (int i = 0; i < 8; i++) pq.push_back(32'hB0 + i);
        repeat (12) step(0, 0);
        chk("s2_all_accepted", pq.size(), 0);
        chk("s2_wr_ready_low", wr_ready, 0);
        for (int i = 0; i < 4; i++) begin
            chk("s2_bank0_mem", mem[i], 32'hB0 + i);
            chk("s2_bank1_mem", mem[4+i], 32'hB4 + i);
        end

        hs_steps.delete();
        pass_cnt = 0;
        pq.push_back($urandom);
        k = 0;
        while (rtiles < 1 && k < 40) begin step(1, pass_cnt >= 1); k++; end
        step(1, 0);
        chk("s3_released", rtiles, 1);
        chk("s3_two_passes", pass_cnt, 2);
        chk("s3_one_bubble", hs_steps.size() >= 5 ? hs_steps[4] - hs_steps[3] : -1, 2);
        chk("s3_stalled_write_next", acc_step - rel_step, 1);

        k = 0;
        while (rtiles < 2 && k < 60) begin step(k % 2 == 0, 1); k++; end
        chk("s4_toggle_released", rtiles, 2);

        for (int i = 0; i < 12; i++) pq.push_back($urandom);
        for (int i = 0; i < 300; i++) begin
            prod_en = $urandom_range(0, 3) != 0;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        prod_en = 1'b1;
        k = 0;
        while ((pq.size() > 0 || done_q.size() > 0) && k < 200) begin step(1, 1); k++; end
        chk("s5_drained", pq.size() + done_q.size(), 0);

        for (int i = 0; i < 4; i++) pq.push_back($urandom);
        hs_steps.delete();
        k = 0;
        while (hs_steps.size() < 2 && k < 40) begin step(1, 0); k++; end
        chk("s6_midstream", hs_steps.size(), 2);
        apply_reset();
        for (int i = 0; i < 4; i++) pq.push_back($urandom);
        k = 0;
        while (rtiles < 1 && k < 40) begin step(1, 1); k++; end
        chk("s6_after_reset", rtiles, 1);
        chk("s6_wr_bank", wtiles, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
